// File: rtl/rv_mdu_pkg.sv
// Shared RV32M multiply/divide definitions: operand width, funct3 decode and divider states.
package rv_mdu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] F3_MUL    = 2'b00;
  localparam logic [1:0] F3_MULH   = 2'b01;
  localparam logic [1:0] F3_MULHSU = 2'b10;
  localparam logic [1:0] F3_MULHU  = 2'b11;

  localparam logic [1:0] F3_DIV  = 2'b00;
  localparam logic [1:0] F3_DIVU = 2'b01;
  localparam logic [1:0] F3_REM  = 2'b10;
  localparam logic [1:0] F3_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  // Two's-complement negate when neg is set, modulo 2^XLEN.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_if.sv
// Core-to-divider handshake: one-cycle start request, busy stall, done strobe with result.
interface div_if;
  import rv_mdu_pkg::*;

  logic            start;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [2:0]      funct3;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] y;

  modport master (output start, a, b, funct3, input busy, done, y);
  modport slave  (input start, a, b, funct3, output busy, done, y);

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring step: shift the next dividend bit into R and try to subtract B.
module div_step
  import rv_mdu_pkg::*;
(
  input  logic [XLEN-1:0] i_r,
  input  logic            i_q_msb,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_r,
  output logic            o_q_bit
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_trial;

  // One extra bit keeps unsigned divisors above 2^(XLEN-1) exact.
  assign w_shift = {i_r, i_q_msb};
  assign w_trial = w_shift - {1'b0, i_b};

  assign o_q_bit = ~w_trial[XLEN];
  assign o_r     = o_q_bit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): XLEN restoring steps plus one sign fix-up cycle.
// Define DIV_EARLY_OUT_EN to skip the iterations for divide-by-zero and signed overflow.
module div
  import rv_mdu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  div_if.slave bus
);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [XLEN-1:0]  r_rem_acc;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_dvsr;
  logic [XLEN-1:0]  r_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_is_rem;

  logic             w_load;
  logic             w_step;
  logic             w_fix;
  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic             w_b_zero;
  logic [XLEN-1:0]  w_mag_a;
  logic [XLEN-1:0]  w_mag_b;
  logic [XLEN-1:0]  w_r_nxt;
  logic             w_q_bit;
  logic             w_unused_f3;
`ifdef DIV_EARLY_OUT_EN
  logic             w_ovf;
`endif

  assign w_signed    = (bus.funct3[1:0] == F3_DIV) || (bus.funct3[1:0] == F3_REM);
  assign w_sa        = w_signed & bus.a[XLEN-1];
  assign w_sb        = w_signed & bus.b[XLEN-1];
  assign w_b_zero    = (bus.b == '0);
  assign w_mag_a     = mag(bus.a, w_sa);
  assign w_mag_b     = mag(bus.b, w_sb);
  assign w_unused_f3 = bus.funct3[2];
`ifdef DIV_EARLY_OUT_EN
  assign w_ovf       = w_signed && (bus.a == XLEN_MIN) && (bus.b == '1);
`endif

  div_step u_step (
    .i_r     (r_rem_acc),
    .i_q_msb (r_quo[XLEN-1]),
    .i_b     (r_dvsr),
    .o_r     (w_r_nxt),
    .o_q_bit (w_q_bit)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CNT_W'(XLEN)) begin
          w_fix       = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem_acc <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_y       <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
    end else begin
      if (w_load) begin
        // The dividend magnitude sits in Q and is shifted into R one bit per step.
        r_rem_acc <= '0;
        r_quo     <= w_mag_a;
        r_dvsr    <= w_mag_b;
        r_cnt     <= '0;
        // Quotient negation is dropped for b == 0 so the all-ones quotient survives.
        r_neg_q   <= (w_sa ^ w_sb) & ~w_b_zero;
        r_neg_r   <= w_sa;
        r_is_rem  <= bus.funct3[1];
`ifdef DIV_EARLY_OUT_EN
        if (w_b_zero) begin
          r_rem_acc <= w_mag_a;
          r_quo     <= '1;
          r_cnt     <= CNT_W'(XLEN);
        end else if (w_ovf) begin
          r_rem_acc <= '0;
          r_quo     <= XLEN_MIN;
          r_cnt     <= CNT_W'(XLEN);
        end
`endif
      end
      if (w_step) begin
        r_rem_acc <= w_r_nxt;
        r_quo     <= {r_quo[XLEN-2:0], w_q_bit};
        r_cnt     <= r_cnt + 1'b1;
      end
      if (w_fix) begin
        r_y <= r_is_rem ? mag(r_rem_acc, r_neg_r) : mag(r_quo, r_neg_q);
      end
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE);
  assign bus.y    = r_y;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: arithmetic reference model, per-cycle compare, directed + random ops.
// Latency expectations follow DIV_EARLY_OUT_EN when the bench is built with it.
module tb_div;
  import rv_mdu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  div_if bus ();

  div dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: one operation in flight at most.
  int          edge_n = 0;
  bit          m_act  = 1'b0;
  int          m_k    = 0;
  int          m_lat  = 0;
  logic [31:0] m_y    = '0;
  logic [31:0] m_hold = '0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  function automatic logic [31:0] ref_y(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3[1:0])
      F3_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f3);
    bit special;
    special = (b == 0) ||
              (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    return (EARLY && special) ? 1 : 33;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: accept start only when idle (from the cycle done drops), result due after L edges.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act  = 1'b0;
      m_hold = '0;
    end else begin
      edge_n++;
      if (m_act && edge_n >= m_k + m_lat + 2) m_act = 1'b0;
      if (!m_act && bus.start) begin
        m_act = 1'b1;
        m_k   = edge_n;
        m_lat = ref_lat(bus.a, bus.b, bus.funct3);
        m_y   = ref_y(bus.a, bus.b, bus.funct3);
      end
      if (m_act && edge_n == m_k + m_lat) m_hold = m_y;
    end
  end

  // Compare process: busy, done and y against the model every cycle out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      logic exp_busy;
      logic exp_done;
      exp_busy = m_act && (edge_n >= m_k) && (edge_n <= m_k + m_lat);
      exp_done = m_act && (edge_n == m_k + m_lat);
      check("cyc_busy", 32'(bus.busy), 32'(exp_busy));
      check("cyc_done", 32'(bus.done), 32'(exp_done));
      check("cyc_y", bus.y, m_hold);
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                          output int k);
    @(posedge clk);
    #1;
    bus.a      = a;
    bus.b      = b;
    bus.funct3 = f3;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k         = edge_n;
  endtask

  task automatic wait_done(input int k, output logic [31:0] y, output int lat);
    bit seen;
    seen = 1'b0;
    y    = 'x;
    lat  = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        y    = bus.y;
        lat  = edge_n - k;
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout got=no_done exp=done_within_60 t=%0t", $time);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                     output logic [31:0] y, output int lat);
    int k;
    start_op(a, b, f3, k);
    wait_done(k, y, lat);
  endtask

  initial begin
    logic [31:0] y;
    int          lat;
    int          k;
    int          zlat;
    zlat = EARLY ? 1 : 33;

    bus.start  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.funct3 = '0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_y", bus.y, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run(32'd100, 32'd7, {1'b0, F3_DIVU}, y, lat);
    check("divu_y", y, 32'd14);
    check("divu_lat", 32'(lat), 32'd33);
    run(32'd100, 32'd7, {1'b0, F3_REMU}, y, lat);
    check("remu_y", y, 32'd2);

    run(32'hFFFF_FFF9, 32'd2, {1'b0, F3_DIV}, y, lat);
    check("div_neg_y", y, 32'hFFFF_FFFD);
    run(32'hFFFF_FFF9, 32'd2, {1'b1, F3_REM}, y, lat);
    check("rem_neg_y", y, 32'hFFFF_FFFF);
    run(32'hFFFF_FFFF, 32'h10, {1'b0, F3_REMU}, y, lat);
    check("remu_big_y", y, 32'h0000_000F);

    run(32'h1234_5678, 32'd0, {1'b0, F3_DIV}, y, lat);
    check("div0_y", y, 32'hFFFF_FFFF);
    check("div0_lat", 32'(lat), 32'(zlat));
    run(32'h1234_5678, 32'd0, {1'b0, F3_REM}, y, lat);
    check("rem0_y", y, 32'h1234_5678);
    check("rem0_lat", 32'(lat), 32'(zlat));

    run(32'h8000_0000, 32'hFFFF_FFFF, {1'b0, F3_DIV}, y, lat);
    check("ovf_div_y", y, 32'h8000_0000);
    check("ovf_div_lat", 32'(lat), 32'(zlat));
    run(32'h8000_0000, 32'hFFFF_FFFF, {1'b0, F3_REM}, y, lat);
    check("ovf_rem_y", y, 32'h0);

    // start re-pulsed mid-operation must be ignored
    start_op(32'd100, 32'd7, {1'b0, F3_DIVU}, k);
    repeat (4) @(posedge clk);
    #1;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(k, y, lat);
    check("ignore_y", y, 32'd14);
    check("ignore_lat", 32'(lat), 32'd33);
    // run() issues the next start in the cycle done drops
    run(32'd1000, 32'd9, {1'b0, F3_DIVU}, y, lat);
    check("b2b_y", y, 32'd111);
    check("b2b_lat", 32'(lat), 32'd33);

    // asynchronous reset during iteration 10
    start_op(32'd500, 32'd3, {1'b0, F3_DIVU}, k);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_y", bus.y, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run(32'hFFFF_FF9C, 32'd10, {1'b0, F3_DIV}, y, lat);
    check("post_rst_y", y, 32'hFFFF_FFF6);

    for (int n = 0; n < 120; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rf;
      ra = $urandom;
      rb = $urandom;
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      start_op(ra, rb, rf, k);
      if (ref_lat(ra, rb, rf) == 33 && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
      wait_done(k, y, lat);
      check("rnd_y", y, ref_y(ra, rb, rf));
      check("rnd_lat", 32'(lat), 32'(ref_lat(ra, rb, rf)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
